// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between an interconnect master port and the RAM slave.
// Carries AW/W/B/AR/R payloads and handshakes; clock and reset stay outside.
interface axi_ram_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();
    // Write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    // Write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    // Write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    // Read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by on-chip RAM with independent write and read FSMs.
// FIXED/INCR bursts up to 256 beats, byte strobes, SLVERR on unsupported bursts.
// Optional: define AXI_RAM_WRAP_BURST_EN to support WRAP bursts of 2/4/8/16 beats.
module axi_ram_slave #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned MEM_ADDR_WIDTH = 10
) (
    input logic            clk,
    input logic            reset,
    axi_ram_slave_if.slave s_axi
);
    localparam int unsigned Offs  = $clog2(STRB_WIDTH);
    localparam int unsigned Depth = 2 ** MEM_ADDR_WIDTH;

    typedef logic [MEM_ADDR_WIDTH-1:0] waddr_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;

    // Flags bursts the RAM will not honour; such bursts complete with SLVERR.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        logic err;
        err = 1'b1;
        case (burst)
            2'b00, 2'b01: err = 1'b0;
`ifdef AXI_RAM_WRAP_BURST_EN
            2'b10: err = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
            2'b10: err = 1'b1 | (^len);
`endif
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Word address of the next beat; WRAP stays inside the aligned (len+1)-word block.
    function automatic waddr_t next_addr(input waddr_t a, input logic [1:0] burst,
                                         input logic [3:0] len_lo);
        waddr_t mask;
        waddr_t inc;
        waddr_t nxt;
        mask = waddr_t'(len_lo);
        inc  = a + waddr_t'(1);
        nxt  = a;
        case (burst)
            2'b01:   nxt = inc;
            2'b10:   nxt = (a & ~mask) | (inc & mask);
            default: nxt = a;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] mem [Depth];

    // Readys are held low for the first cycle after reset so every output reads 0 then.
    logic rdy_en_q;

    w_state_e            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    waddr_t              w_addr_q, w_addr_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [1:0]          w_burst_q, w_burst_d;
    logic                w_err_q, w_err_d;
    logic [7:0]          w_cnt_q, w_cnt_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                mem_we;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    waddr_t                r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  r_err_q, r_err_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic awready, wready, bvalid, arready, rvalid, rlast;
    logic w_at_len;

    // Write FSM: accept AW, sink W beats into RAM, then return one B response.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        mem_we    = 1'b0;
        w_at_len  = (w_cnt_q == w_len_q);
        case (w_state_q)
            W_IDLE: begin
                awready = rdy_en_q;
                if (s_axi.awvalid && rdy_en_q) begin
                    w_id_d    = s_axi.awid;
                    w_addr_d  = s_axi.awaddr[MEM_ADDR_WIDTH+Offs-1:Offs];
                    w_len_d   = s_axi.awlen;
                    w_burst_d = s_axi.awburst;
                    w_err_d   = burst_err(s_axi.awburst, s_axi.awlen);
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (s_axi.wvalid) begin
                    mem_we   = !w_err_q;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_addr_d = next_addr(w_addr_q, w_burst_q, w_len_q[3:0]);
                    // A misplaced or missing wlast still ends the burst, but as SLVERR.
                    if (s_axi.wlast || w_at_len) begin
                        bresp_d   = (w_err_q || (s_axi.wlast != w_at_len)) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: accept AR, then alternate a RAM read cycle with one R beat.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = rdy_en_q;
                if (s_axi.arvalid && rdy_en_q) begin
                    r_id_d    = s_axi.arid;
                    r_addr_d  = s_axi.araddr[MEM_ADDR_WIDTH+Offs-1:Offs];
                    r_len_d   = s_axi.arlen;
                    r_burst_d = s_axi.arburst;
                    r_err_d   = burst_err(s_axi.arburst, s_axi.arlen);
                    r_cnt_d   = 8'd0;
                    r_state_d = R_READ;
                end
            end
            R_READ: begin
                rdata_d   = r_err_q ? '0 : mem[r_addr_q];
                r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt_q == r_len_q);
                if (s_axi.rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = next_addr(r_addr_q, r_burst_q, r_len_q[3:0]);
                        r_state_d = R_READ;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers for both FSMs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_en_q  <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_cnt_q   <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_WIDTH); i++) begin
                if (s_axi.wstrb[i]) begin
                    mem[w_addr_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
                end
            end
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bid     = w_id_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rlast   = rlast;
    assign s_axi.rid     = r_id_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = r_err_q ? 2'b10 : 2'b00;

    // Size fields and out-of-range address bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awsize, s_axi.arsize,
                           s_axi.awaddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+Offs], s_axi.awaddr[Offs-1:0],
                           s_axi.araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+Offs], s_axi.araddr[Offs-1:0]};
endmodule
